// File: rtl/exec_pkg.sv
// exec_pkg: opcode, shift, type and condition constants plus the condition evaluator for the execute stage
package exec_pkg;
  localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF;
  localparam logic [1:0] SH_LSL = 2'd0, SH_LSR = 2'd1, SH_ASR = 2'd2, SH_ROR = 2'd3;
  localparam logic [3:0] TYPE_DP = 4'd0, TYPE_BR = 4'd1;
  localparam logic [3:0] CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3;
  localparam logic [3:0] CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7;
  localparam logic [3:0] CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB;
  localparam logic [3:0] CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF;
  typedef struct packed {
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        br;
    logic [31:0] target;
  } result_t;
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    cond_pass = 1'b0;
    case (cond)
      CC_EQ: cond_pass = z;
      CC_NE: cond_pass = !z;
      CC_CS: cond_pass = c;
      CC_CC: cond_pass = !c;
      CC_MI: cond_pass = n;
      CC_PL: cond_pass = !n;
      CC_VS: cond_pass = v;
      CC_VC: cond_pass = !v;
      CC_HI: cond_pass = c && !z;
      CC_LS: cond_pass = !c || z;
      CC_GE: cond_pass = n == v;
      CC_LT: cond_pass = n != v;
      CC_GT: cond_pass = !z && (n == v);
      CC_LE: cond_pass = z || (n != v);
      CC_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/execute_stage_if.sv
// execute_stage_if: decoded-instruction input and writeback/branch result bundle
interface execute_stage_if;
  logic        in_valid, in_ready;
  logic [31:0] in_op1, in_op2, in_instr;
  logic [4:0]  in_shamt;
  logic [3:0]  in_type, in_dst;
  logic        out_valid, out_ready, wb_en, branch_taken;
  logic [3:0]  wb_addr, flags_nzcv;
  logic [31:0] wb_data, branch_target;
  modport slave(
    input  in_valid, in_op1, in_op2, in_shamt, in_type, in_instr, in_dst, out_ready,
    output in_ready, out_valid, wb_en, wb_addr, wb_data, branch_taken, branch_target, flags_nzcv
  );
  modport master(
    output in_valid, in_op1, in_op2, in_shamt, in_type, in_instr, in_dst, out_ready,
    input  in_ready, out_valid, wb_en, wb_addr, wb_data, branch_taken, branch_target, flags_nzcv
  );
endinterface

// File: rtl/barrel_shifter.sv
// barrel_shifter: ARM shifter operand with carry-out, including the imm5=0 special encodings
module barrel_shifter
  import exec_pkg::*;
(
  input  logic [31:0] i_value,
  input  logic [4:0]  i_amount,
  input  logic [1:0]  i_type,
  input  logic        i_imm_form,
  input  logic        i_carry,
  output logic [31:0] o_result,
  output logic        o_carry
);
  logic [32:0] w_lsl, w_lsr, w_asr;
  logic [31:0] w_ror;
  // the extra bit on each side catches the last bit shifted out
  assign w_lsl = {1'b0, i_value} << i_amount;
  assign w_lsr = {i_value, 1'b0} >> i_amount;
  assign w_asr = $signed({i_value, 1'b0}) >>> i_amount;
  assign w_ror = (i_value >> i_amount) | (i_value << (6'd32 - {1'b0, i_amount}));
  always_comb begin
    {o_carry, o_result} = {i_carry, i_value};
    if (i_amount != 5'd0)
      case (i_type)
        SH_LSL:  {o_carry, o_result} = w_lsl;
        SH_LSR:  {o_carry, o_result} = {w_lsr[0], w_lsr[32:1]};
        SH_ASR:  {o_carry, o_result} = {w_asr[0], w_asr[32:1]};
        default: {o_carry, o_result} = {w_ror[31], w_ror};
      endcase
    else if (i_imm_form)
      case (i_type)
        SH_LSR:  {o_carry, o_result} = {i_value[31], 32'd0};
        SH_ASR:  {o_carry, o_result} = {i_value[31], {32{i_value[31]}}};
        SH_ROR:  {o_carry, o_result} = {i_value[0], i_carry, i_value[31:1]};
        default: ;
      endcase
  end
endmodule

// File: rtl/execute_stage.sv
// execute_stage: condition check, shifter, ALU/branch and NZCV update with a one-deep registered result
module execute_stage
  import exec_pkg::*;
(
  input logic             clk,
  input logic             reset,
  execute_stage_if.slave  bus
);
  logic        r_valid;
  result_t     r_res;
  logic [3:0]  r_flags;
  result_t     w_next;
  logic [3:0]  w_next_flags, w_op, w_dp_flags;
  logic [31:0] w_sh, w_x, w_y, w_logic, w_res;
  logic [32:0] w_sum;
  logic        w_sh_c, w_cin, w_v, w_arith, w_test, w_pass, w_accept;
  assign w_op = bus.in_instr[24:21];
  assign w_pass = cond_pass(bus.in_instr[31:28], r_flags);
  assign w_accept = bus.in_valid && bus.in_ready;
  barrel_shifter u_shifter (
    .i_value   (bus.in_op2),
    .i_amount  (bus.in_shamt),
    .i_type    (bus.in_instr[25] ? SH_ROR : bus.in_instr[6:5]),
    .i_imm_form(!bus.in_instr[25] && !bus.in_instr[4]),
    .i_carry   (r_flags[1]),
    .o_result  (w_sh),
    .o_carry   (w_sh_c)
  );
  // one adder serves all eight arithmetic ops; reverse ops swap operands, subtracts invert
  assign w_arith = w_op inside {OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC, OP_CMP, OP_CMN};
  assign w_test = w_op[3:2] == 2'b10;
  assign w_x = (w_op == OP_RSB || w_op == OP_RSC) ? w_sh : bus.in_op1;
  assign w_y = (w_op == OP_RSB || w_op == OP_RSC) ? ~bus.in_op1 :
               (w_op inside {OP_SUB, OP_SBC, OP_CMP}) ? ~w_sh : w_sh;
  assign w_cin = (w_op inside {OP_SUB, OP_RSB, OP_CMP}) ? 1'b1 :
                 (w_op inside {OP_ADC, OP_SBC, OP_RSC}) ? r_flags[1] : 1'b0;
  assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {32'd0, w_cin};
  assign w_v = (w_x[31] == w_y[31]) && (w_sum[31] != w_x[31]);
  assign w_logic = (w_op == OP_AND || w_op == OP_TST) ? bus.in_op1 & w_sh :
                   (w_op == OP_EOR || w_op == OP_TEQ) ? bus.in_op1 ^ w_sh :
                   w_op == OP_ORR ? bus.in_op1 | w_sh :
                   w_op == OP_MOV ? w_sh :
                   w_op == OP_BIC ? bus.in_op1 & ~w_sh : ~w_sh;
  assign w_res = w_arith ? w_sum[31:0] : w_logic;
  assign w_dp_flags = w_arith ? {w_res[31], w_res == 32'd0, w_sum[32], w_v}
                              : {w_res[31], w_res == 32'd0, w_sh_c, r_flags[0]};
  always_comb begin
    w_next = '0;
    w_next_flags = r_flags;
    if (w_pass && bus.in_type == TYPE_DP) begin
      w_next.wb_en = !w_test;
      w_next.wb_addr = bus.in_dst;
      w_next.wb_data = w_res;
      w_next.br = !w_test && bus.in_dst == 4'd15;
      w_next.target = w_res;
      w_next_flags = (bus.in_instr[20] || w_test) ? w_dp_flags : r_flags;
    end else if (w_pass && bus.in_type == TYPE_BR) begin
      w_next.wb_en = bus.in_instr[24];
      w_next.wb_addr = 4'd14;
      w_next.wb_data = bus.in_op1 - 32'd4;
      w_next.br = 1'b1;
      w_next.target = bus.in_op1 + {{6{bus.in_instr[23]}}, bus.in_instr[23:0], 2'b00};
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_res <= '0;
      r_flags <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_res <= w_next;
      r_flags <= w_next_flags;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end
  assign bus.in_ready = !r_valid || bus.out_ready;
  assign bus.out_valid = r_valid;
  assign bus.wb_en = r_valid && r_res.wb_en;
  assign bus.wb_addr = r_res.wb_addr;
  assign bus.wb_data = r_res.wb_data;
  assign bus.branch_taken = r_valid && r_res.br;
  assign bus.branch_target = r_res.target;
  assign bus.flags_nzcv = r_flags;
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed vectors checked every cycle against an architectural model of the stage
module tb_execute_stage;
  typedef struct packed {
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        br;
    logic [31:0] target;
    logic [3:0]  flags;
  } exp_t;
  localparam longint MAXS = 64'sh7FFFFFFF;
  localparam longint MINS = -64'sh80000000;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  exp_t q[$];
  exp_t m_e, p;
  logic [3:0] m_flags = 4'd0;
  always #5 clk = ~clk;
  execute_stage_if bus();
  execute_stage dut(.clk(clk), .reset(reset), .bus(bus));
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic passes(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      0: return z;       1: return !z;      2: return c;       3: return !c;
      4: return n;       5: return !n;      6: return v;       7: return !v;
      8: return c & !z;  9: return !c | z;  10: return n == v; 11: return n != v;
      12: return !z && n == v;  13: return z || n != v;  14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
  function automatic exp_t model(input logic [31:0] instr, op1, op2, input logic [4:0] shamt,
                                 input logic [3:0] typ, dst, fl);
    exp_t e;
    logic [31:0] b, r;
    logic [63:0] t;
    logic [3:0] op;
    logic c_sh, c, v, arith, is_sub, swap, test;
    longint ux, uy, sx, sy, k, u, s, tmp;
    int n;
    e = '0;
    e.flags = fl;
    if (!passes(instr[31:28], fl)) return e;
    if (typ == 4'd1) begin
      e.br = 1'b1;
      e.target = op1 + ({{8{instr[23]}}, instr[23:0]} << 2);
      if (instr[24]) begin
        e.wb_en = 1'b1;
        e.wb_addr = 4'd14;
        e.wb_data = op1 - 32'd4;
      end
      return e;
    end
    if (typ != 4'd0) return e;
    b = op2;
    c_sh = fl[1];
    n = int'(shamt);
    if (instr[25]) begin
      if (n != 0) begin
        t = {op2, op2} >> n;
        b = t[31:0];
        c_sh = b[31];
      end
    end else if (n == 0 && !instr[4] && instr[6:5] == 2'd3) begin
      b = {fl[1], op2[31:1]};
      c_sh = op2[0];
    end else begin
      if (n == 0 && !instr[4] && instr[6:5] != 2'd0) n = 32;
      if (n != 0)
        case (instr[6:5])
          2'd0: begin t = {32'd0, op2} << n; b = t[31:0]; c_sh = t[32]; end
          2'd1: begin t = {op2, 32'd0} >> n; b = t[63:32]; c_sh = t[31]; end
          2'd2: begin t = $signed({op2, 32'd0}) >>> n; b = t[63:32]; c_sh = t[31]; end
          default: begin t = {op2, op2} >> n; b = t[31:0]; c_sh = b[31]; end
        endcase
    end
    op = instr[24:21];
    test = op >= 4'd8 && op <= 4'd11;
    arith = 1'b1; is_sub = 1'b0; swap = 1'b0; k = 0;
    case (op)
      2, 10: is_sub = 1'b1;
      3: begin is_sub = 1'b1; swap = 1'b1; end
      4, 11: ;
      5: k = longint'(fl[1]);
      6: begin is_sub = 1'b1; k = longint'(!fl[1]); end
      7: begin is_sub = 1'b1; swap = 1'b1; k = longint'(!fl[1]); end
      default: arith = 1'b0;
    endcase
    ux = longint'(op1); uy = longint'(b);
    sx = longint'($signed(op1)); sy = longint'($signed(b));
    if (swap) begin
      tmp = ux; ux = uy; uy = tmp;
      tmp = sx; sx = sy; sy = tmp;
    end
    u = is_sub ? ux - uy - k : ux + uy + k;
    s = is_sub ? sx - sy - k : sx + sy + k;
    c = is_sub ? (u >= 0) : ((u >>> 32) != 0);
    v = s > MAXS || s < MINS;
    case (op)
      0, 8: r = op1 & b;
      1, 9: r = op1 ^ b;
      12: r = op1 | b;
      13: r = b;
      14: r = op1 & ~b;
      15: r = ~b;
      default: r = u[31:0];
    endcase
    if (instr[20] || test)
      e.flags = arith ? {r[31], r == 32'd0, c, v} : {r[31], r == 32'd0, c_sh, fl[0]};
    e.wb_en = !test;
    e.wb_addr = dst;
    e.wb_data = r;
    e.br = !test && dst == 4'd15;
    e.target = r;
    return e;
  endfunction
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_flags = 4'd0;
    end else begin
      if (bus.out_valid && bus.out_ready && q.size() > 0) void'(q.pop_front());
      if (bus.in_valid && bus.in_ready) begin
        m_e = model(bus.in_instr, bus.in_op1, bus.in_op2, bus.in_shamt, bus.in_type, bus.in_dst, m_flags);
        q.push_back(m_e);
        m_flags = m_e.flags;
      end
    end
  end
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("flags", {28'd0, bus.flags_nzcv}, {28'd0, m_flags});
      check("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() != 0});
      check("in_ready", {31'd0, bus.in_ready}, {31'd0, q.size() == 0 || bus.out_ready});
      if (q.size() != 0) begin
        check("wb_en", {31'd0, bus.wb_en}, {31'd0, q[0].wb_en});
        check("branch_taken", {31'd0, bus.branch_taken}, {31'd0, q[0].br});
        if (q[0].wb_en) check("wb_addr", {28'd0, bus.wb_addr}, {28'd0, q[0].wb_addr});
        if (q[0].wb_en) check("wb_data", bus.wb_data, q[0].wb_data);
        if (q[0].br) check("branch_target", bus.branch_target, q[0].target);
      end else begin
        check("wb_en_idle", {31'd0, bus.wb_en}, 32'd0);
        check("branch_idle", {31'd0, bus.branch_taken}, 32'd0);
      end
    end
  end
  task automatic drive(input logic [31:0] instr, op1, op2, input logic [4:0] shamt,
                       input logic [3:0] typ, dst);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_op1 = op1;
    bus.in_op2 = op2;
    bus.in_shamt = shamt;
    bus.in_type = typ;
    bus.in_dst = dst;
  endtask
  task automatic send(input logic [31:0] instr, op1, op2, input logic [4:0] shamt,
                      input logic [3:0] typ, dst);
    logic ok;
    drive(instr, op1, op2, shamt, typ, dst);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: instr 0x%08h not accepted, required within 20 cycles", instr);
    end
    bus.in_valid = 1'b0;
  endtask
  initial begin
    p = model(32'hE0912003, 32'h7FFFFFFF, 32'd1, 5'd0, 4'd0, 4'd2, 4'b0000);
    check("pin_adds_data", p.wb_data, 32'h80000000);
    check("pin_adds_flags", {28'd0, p.flags}, 32'b1001);
    check("pin_adds_addr", {28'd0, p.wb_addr}, 32'd2);
    p = model(32'hE1510002, 32'd5, 32'd5, 5'd0, 4'd0, 4'd1, 4'b1001);
    check("pin_cmp_wb", {31'd0, p.wb_en}, 32'd0);
    check("pin_cmp_flags", {28'd0, p.flags}, 32'b0110);
    p = model(32'h10912003, 32'd1, 32'd1, 5'd0, 4'd0, 4'd2, 4'b0110);
    check("pin_addne_wb", {31'd0, p.wb_en}, 32'd0);
    p = model(32'hE1B00020, 32'd0, 32'h80000000, 5'd0, 4'd0, 4'd0, 4'b0110);
    check("pin_lsr32_data", p.wb_data, 32'd0);
    check("pin_lsr32_flags", {28'd0, p.flags}, 32'b0110);
    p = model(32'hE1B04060, 32'd0, 32'd2, 5'd0, 4'd0, 4'd4, 4'b0110);
    check("pin_rrx_data", p.wb_data, 32'h80000001);
    check("pin_rrx_flags", {28'd0, p.flags}, 32'b1000);
    p = model(32'hEBFFFFFE, 32'h108, 32'd0, 5'd0, 4'd1, 4'd15, 4'b0000);
    check("pin_bl_target", p.target, 32'h100);
    check("pin_bl_data", p.wb_data, 32'h104);
    check("pin_bl_addr", {28'd0, p.wb_addr}, 32'd14);
    p = model(32'hE3B074FF, 32'd0, 32'hFF, 5'd8, 4'd0, 4'd7, 4'b0000);
    check("pin_rot_data", p.wb_data, 32'hFF000000);
    check("pin_rot_flags", {28'd0, p.flags}, 32'b1010);
    p = model(32'hE0515002, 32'd3, 32'd5, 5'd0, 4'd0, 4'd5, 4'b0000);
    check("pin_subs_data", p.wb_data, 32'hFFFFFFFE);
    check("pin_subs_flags", {28'd0, p.flags}, 32'b1000);
    bus.out_ready = 1'b1;
    drive(32'hE0912003, 32'd1, 32'd1, 5'd0, 4'd0, 4'd2);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("reset_flags", {28'd0, bus.flags_nzcv}, 32'd0);
    check("reset_wb_addr", {28'd0, bus.wb_addr}, 32'd0);
    check("reset_wb_data", bus.wb_data, 32'd0);
    check("reset_target", bus.branch_target, 32'd0);
    send(32'hE0912003, 32'h7FFFFFFF, 32'd1, 5'd0, 4'd0, 4'd2);
    send(32'hE1510002, 32'd5, 32'd5, 5'd0, 4'd0, 4'd1);
    send(32'h10912003, 32'd1, 32'd1, 5'd0, 4'd0, 4'd2);
    send(32'hE1B00020, 32'd0, 32'h80000000, 5'd0, 4'd0, 4'd0);
    send(32'hE1B04060, 32'd0, 32'd2, 5'd0, 4'd0, 4'd4);
    send(32'hEBFFFFFE, 32'h108, 32'd0, 5'd0, 4'd1, 4'd15);
    send(32'hE0515002, 32'd3, 32'd5, 5'd0, 4'd0, 4'd5);
    send(32'hE0B16002, 32'hFFFFFFFF, 32'd1, 5'd0, 4'd0, 4'd6);
    send(32'hE0D16002, 32'd5, 32'd3, 5'd0, 4'd0, 4'd6);
    send(32'hE0F16002, 32'd1, 32'd0, 5'd0, 4'd0, 4'd6);
    send(32'hE3B074FF, 32'd0, 32'hFF, 5'd8, 4'd0, 4'd7);
    send(32'hE0818312, 32'd1, 32'd7, 5'd0, 4'd0, 4'd8);
    send(32'hE1B01242, 32'd0, 32'h80000010, 5'd4, 4'd0, 4'd1);
    send(32'hE1A0F002, 32'd0, 32'h200, 5'd0, 4'd0, 4'd15);
    send(32'hE1310002, 32'd9, 32'd9, 5'd0, 4'd0, 4'd0);
    send(32'h0A000001, 32'h200, 32'd0, 5'd0, 4'd1, 4'd15);
    send(32'hF0912003, 32'd1, 32'd1, 5'd0, 4'd0, 4'd2);
    send(32'hE0912003, 32'd1, 32'd1, 5'd0, 4'd5, 4'd2);
    send(32'hE1913002, 32'hF0, 32'h0F, 5'd0, 4'd0, 4'd3);
    send(32'hE0313002, 32'hFF, 32'hFF, 5'd0, 4'd0, 4'd3);
    send(32'hE0713002, 32'd5, 32'd3, 5'd0, 4'd0, 4'd3);
    send(32'hE1710002, 32'h7FFFFFFF, 32'd1, 5'd0, 4'd0, 4'd0);
    send(32'hE1F03002, 32'd0, 32'd0, 5'd0, 4'd0, 4'd3);
    send(32'hE1D13002, 32'hFF, 32'h0F, 5'd0, 4'd0, 4'd3);
    send(32'hE1110002, 32'hF0, 32'h0F, 5'd0, 4'd0, 4'd0);
    send(32'hE0113002, 32'h80000001, 32'h80000003, 5'd0, 4'd0, 4'd3);
    send(32'hE0912083, 32'h80000000, 32'h80000000, 5'd1, 4'd0, 4'd9);
    repeat (2) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(32'hE0803002, 32'd1, 32'd2, 5'd0, 4'd0, 4'd3);
    drive(32'hE0804002, 32'd10, 32'd20, 5'd0, 4'd0, 4'd4);
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("bp_hold_data", bus.wb_data, 32'd3);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("bp_second_addr", {28'd0, bus.wb_addr}, 32'd4);
    check("bp_second_data", bus.wb_data, 32'd30);
    @(posedge clk);
    #1;
    check("bp_drained", {31'd0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b0;
    send(32'hE0915002, 32'hFFFFFFFF, 32'd1, 5'd0, 4'd0, 4'd5);
    drive(32'hE0806002, 32'd1, 32'd1, 5'd0, 4'd0, 4'd6);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    check("midreset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midreset_flags", {28'd0, bus.flags_nzcv}, 32'd0);
    check("midreset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/execute_stage.md
# execute_stage

Synchronous execute stage directly downstream of the instruction decoder. It accepts one decoded instruction per valid/ready handshake: operands, shift amount, type code, original instruction word and destination. It performs the condition check, the shifter operand, the ALU operation or branch-target computation, and the NZCV update. It presents a registered writeback/branch result to the register bank and the fetch/issue stage.

## Interface
Parameters:
- none (widths fixed by the 32-bit ISA)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage can accept this cycle
- in_op1  in  32  Rn value (type 0) or PC value (type 1)
- in_op2  in  32  Rm value, or zero-extended imm8 when instr[25]=1
- in_shamt  in  5  shift/rotate amount (imm5, Rs[4:0], or 2*rot4)
- in_type  in  4  0 = data processing, 1 = branch, others = no-op
- in_instr  in  32  original instruction word
- in_dst  in  4  destination register (Rd, or 15 for branch)
- out_valid  out  1  result register holds a retired instruction
- out_ready  in  1  consumer accepts result
- wb_en  out  1  write wb_data to wb_addr
- wb_addr  out  4  writeback register
- wb_data  out  32  writeback value
- branch_taken  out  1  redirect fetch to branch_target
- branch_target  out  32  new PC
- flags_nzcv  out  4  current N,Z,C,V (architectural CPSR flags)

## Operation
- Accept when in_valid && in_ready; in_ready = !out_valid || out_ready.
- Condition in_instr[31:28] is evaluated against flags_nzcv as held before acceptance, using the standard ARM 16 codes. NV (4'hF) counts as fail.
- Condition fail: retire as a no-op. out_valid=1, wb_en=0, branch_taken=0, flags unchanged.
- Type 0, shifter operand:
  - instr[25]=1: in_op2 ROR in_shamt. When in_shamt≠0, C_sh = bit31 of the result; otherwise C_sh = C.
  - instr[25]=0: shift type instr[6:5] (LSL/LSR/ASR/ROR).
    - Immediate form (instr[4]=0), in_shamt=0: LSL passes the operand unchanged with C_sh=C; LSR means shift 32; ASR means shift 32; ROR means RRX.
    - Register form (instr[4]=1), in_shamt=0: operand unchanged, C_sh=C.
- Type 0, ALU: opcode instr[24:21], all 16 ops (AND EOR SUB RSB ADD ADC SBC RSC TST TEQ CMP CMN ORR MOV BIC MVN). Arithmetic is 33-bit.
  - Subtraction C = NOT borrow.
  - V = signed overflow of the 32-bit operation.
- Flags update only when instr[20]=1. TST/TEQ/CMP/CMN update flags regardless of S.
  - Logical ops: N, Z from result; C=C_sh; V unchanged.
  - Arithmetic ops: N, Z, C, V from the adder.
- Writeback: wb_en=1 except for TST/TEQ/CMP/CMN. wb_addr=in_dst.
- in_dst=15 with wb_en: also branch_taken=1, branch_target=result.
- Type 1 (B/BL): branch_target = in_op1 + sign_extend(instr[23:0])<<2, branch_taken=1.
  - BL (instr[24]=1): wb_en=1, wb_addr=14, wb_data=in_op1-4.
  - Flags never change on a branch.
- Other types: no-op retirement.

## Timing
- Latency 1 cycle: an instruction accepted at edge N has its result visible after edge N and flags updated at that same edge. A back-to-back instruction accepted at edge N+1 sees the new flags.
- Result outputs are stable while out_valid && !out_ready.
- Simultaneous out_ready and in_valid with out_valid=1 gives full throughput (1/cycle).
- wb_en and branch_taken are qualified by out_valid. When out_valid=0 they are driven 0.
- Reset, taking effect at the clock edge even mid-handshake:
  - out_valid=0, wb_en=0, wb_addr=0, wb_data=0, branch_taken=0, branch_target=0, flags_nzcv=0.
  - in_ready=1 on the first cycle after reset.
  - Any held result is discarded.

## Structure
- Package `exec_pkg` holds:
  - opcode localparams (AND..MVN)
  - shift type codes
  - type codes (TYPE_DP=0, TYPE_BR=1)
  - condition code constants
  - a cond_pass function
- Sub-module `barrel_shifter`, combinational: inputs value, amount, shift type, imm/reg form, carry_in; outputs result, carry_out.
- The top level holds the ALU, flag logic and the output register.

## Test plan
- Reset: assert reset for 2 cycles with in_valid=1 -> out_valid=0, flags_nzcv=0, in_ready=1.
- ADDS r2 (instr 0xE0912003, op1=0x7FFFFFFF, op2=1, shamt=0) -> wb_addr=2, wb_data=0x80000000, NZCV=1001.
- CMP (0xE1510002, op1=5, op2=5) -> wb_en=0, NZCV=0110. The next ADDNE is accepted the following cycle and retires as a no-op.
- Shifts:
  - MOVS with LSR imm #0, op2=0x80000000 -> wb_data=0, C=1, Z=1.
  - RRX with C=1, op2=2 -> wb_data=0x80000001, C=0.
- BL (0xEBFFFFFE, op1=0x108) -> branch_target=0x100, wb_addr=14, wb_data=0x104.
- Backpressure: hold out_ready=0 for 3 cycles with 2 instructions offered -> first result held stable, in_ready=0. Release -> both retire in order on consecutive cycles.
